// File: rtl/im_arbiter_if.sv
// Bundle of the two requester ports and the instruction-memory port served by im_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface im_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    logic          rready0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rvalid1;
    logic          rready1;
    logic [DW-1:0] rdata1;

    logic          im_ren;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_rdata;

    modport slave (
        input  req0, addr0, rready0, req1, addr1, rready1, im_rdata,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, im_ren, im_addr
    );

    modport master (
        output req0, addr0, rready0, req1, addr1, rready1, im_rdata,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, im_ren, im_addr
    );
endinterface

// File: rtl/im_arbiter.sv
// Two-port arbiter for the synchronous-read instruction memory port (port 0 = fetch, port 1 = debug).
// Define IM_ARB_RR_EN for round-robin collision handling; otherwise port 0 has fixed priority.
module im_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned INIT_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    im_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY} state_t;

    localparam int unsigned CW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    // INIT lasts exactly INIT_WAIT cycles after reset release, so a grant can land on cycle INIT_WAIT+1
    localparam logic [CW-1:0] CNT_LAST  = CW'((INIT_WAIT > 0) ? (INIT_WAIT - 1) : 0);
    localparam state_t        RST_STATE = (INIT_WAIT == 0) ? ST_IDLE : ST_INIT;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          any_req;
    logic          win;
    logic          accept;
    logic          gnt0_c, gnt1_c, ren_c, rvalid0_c, rvalid1_c;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] rdata_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign any_req = bus.req0 | bus.req1;

`ifdef IM_ARB_RR_EN
    assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
`else
    assign win = bus.req1 & ~bus.req0;
`endif

    // A new read may issue when nothing is outstanding or the owner drains its response now
    assign accept = (state_q == ST_IDLE) ||
                    ((state_q == ST_BUSY) && (owner_q ? bus.rready1 : bus.rready0));

    // Next-state and combinational outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        ren_c     = 1'b0;
        rvalid0_c = 1'b0;
        rvalid1_c = 1'b0;
        win_addr  = '0;

        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (state_q == ST_BUSY) begin
                    rvalid0_c = ~owner_q;
                    rvalid1_c = owner_q;
                end
                if (accept) begin
                    if (any_req) begin
                        ren_c    = 1'b1;
                        gnt0_c   = ~win;
                        gnt1_c   = win;
                        win_addr = win ? bus.addr1 : bus.addr0;
                        owner_d  = win;
                        last_d   = win;
                        state_d  = ST_BUSY;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
        endcase

        // Reset masks every handshake output, including a response still pending
        if (reset) begin
            gnt0_c    = 1'b0;
            gnt1_c    = 1'b0;
            ren_c     = 1'b0;
            rvalid0_c = 1'b0;
            rvalid1_c = 1'b0;
            win_addr  = '0;
        end
    end

    assign rdata_c     = bus.im_rdata;
    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.rvalid0 = rvalid0_c;
    assign bus.rvalid1 = rvalid1_c;
    assign bus.rdata0  = rdata_c;
    assign bus.rdata1  = rdata_c;
    assign bus.im_ren  = ren_c;
    assign bus.im_addr = win_addr;
endmodule

// File: tb/tb_im_arbiter.sv
// Scoreboard bench for im_arbiter: directed scenarios followed by randomized traffic against a behavioural model.
module tb_im_arbiter;
    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned INIT_WAIT = 2;

    logic clk;
    logic reset;

    im_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    im_arbiter #(.AW(AW), .DW(DW), .INIT_WAIT(INIT_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: synchronous read, output held while ren is low
    logic [DW-1:0] mem [0:1023];
    always_ff @(posedge clk) begin
        if (bus.im_ren) bus.im_rdata <= mem[bus.im_addr[11:2]];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_out;
    logic          m_owner;
    logic          m_last;
    int            m_init_left;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [9:0] idx;
        idx = 10'((a >> 2) % 1024);
        return mem[idx];
    endfunction

    // Drive one cycle of inputs, then compare the DUT's handshake outputs with the model
    task automatic cycle(input logic rst,
                         input logic r0, input logic [AW-1:0] a0, input logic rr0,
                         input logic r1, input logic [AW-1:0] a1, input logic rr1,
                         output logic g0, output logic g1);
        logic [4:0]    exp_v;
        logic [AW-1:0] exp_addr;
        logic          window;
        logic          w;
        @(negedge clk);
        reset       = rst;
        bus.req0    = r0;
        bus.addr0   = a0;
        bus.rready0 = rr0;
        bus.req1    = r1;
        bus.addr1   = a1;
        bus.rready1 = rr1;
        #1;
        exp_v    = '0;
        exp_addr = '0;
        g0       = 1'b0;
        g1       = 1'b0;
        if (rst) begin
            m_out       = 1'b0;
            m_owner     = 1'b0;
            m_last      = 1'b1;
            m_init_left = INIT_WAIT;
            q0.delete();
            q1.delete();
            check("reset_addr", 64'(bus.im_addr), 64'(0));
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            exp_v[1] = m_out && !m_owner;
            exp_v[0] = m_out && m_owner;
            window   = !m_out || (m_owner ? rr1 : rr0);
            if (window && (r0 || r1)) begin
`ifdef IM_ARB_RR_EN
                w = (r0 && r1) ? !m_last : r1;
`else
                w = r1 && !r0;
`endif
                exp_v[2] = 1'b1;
                if (w) begin
                    exp_v[3] = 1'b1;
                    exp_addr = a1;
                    q1.push_back(mem_word(a1));
                end else begin
                    exp_v[4] = 1'b1;
                    exp_addr = a0;
                    q0.push_back(mem_word(a0));
                end
                m_out   = 1'b1;
                m_owner = w;
                m_last  = w;
                g0      = !w;
                g1      = w;
            end else if (window) begin
                m_out = 1'b0;
            end
        end
        check("gnt0_gnt1_ren_rv0_rv1",
              64'({bus.gnt0, bus.gnt1, bus.im_ren, bus.rvalid0, bus.rvalid1}), 64'(exp_v));
        if (exp_v[2]) check("im_addr", 64'(bus.im_addr), 64'(exp_addr));
    endtask

    // Monitor: every presented response must match the head of its port's queue
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.rvalid0) begin
                if (q0.size() == 0) begin
                    check("rvalid0_unexpected", 64'(1), 64'(0));
                end else begin
                    check("rdata0", 64'(bus.rdata0), 64'(q0[0]));
                    if (bus.rready0) void'(q0.pop_front());
                end
            end
            if (bus.rvalid1) begin
                if (q1.size() == 0) begin
                    check("rvalid1_unexpected", 64'(1), 64'(0));
                end else begin
                    check("rdata1", 64'(bus.rdata1), 64'(q1[0]));
                    if (bus.rready1) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        logic          g0, g1;
        logic          h0, h1;
        logic [AW-1:0] a0, a1;
        int            first, n0, n1, k0, k1, nren;

        reset       = 1'b1;
        bus.req0    = 1'b0;
        bus.addr0   = '0;
        bus.rready0 = 1'b0;
        bus.req1    = 1'b0;
        bus.addr1   = '0;
        bus.rready1 = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[2] = 32'hDEADBEEF;

        // Reset: everything quiet
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, g0, g1);

        // First grant after the init wait
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, g0, g1);
            if (bus.gnt0 && first == 0) first = i;
            if (g0) break;
        end
        check("first_gnt0_cycle", 64'(first), 64'(INIT_WAIT + 1));

        // Collision with both ports requesting for four grants
        n0 = 0; n1 = 0; k0 = 1; k1 = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, AW'(4 * k0), 1'b1, 1'b1, AW'(32'h100 + 4 * k1), 1'b1, g0, g1);
            if (bus.gnt0) n0++;
            if (bus.gnt1) n1++;
            if (g0) k0++;
            if (g1) k1++;
        end
`ifdef IM_ARB_RR_EN
        check("collision_gnt0_count", 64'(n0), 64'(2));
        check("collision_gnt1_count", 64'(n1), 64'(2));
`else
        check("collision_gnt0_count", 64'(n0), 64'(4));
        check("collision_gnt1_count", 64'(n1), 64'(0));
`endif
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, g0, g1);

        // Backpressure on port 0 while port 1 waits
        cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, g0, g1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, g0, g1);
            check("bp_rdata0", 64'(bus.rdata0), 64'(32'hDEADBEEF));
            check("bp_gnt1_ren", 64'({bus.gnt1, bus.im_ren}), 64'(0));
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b1, g0, g1);
        check("bp_release_gnt1", 64'(bus.gnt1), 64'(1));
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, g0, g1);

        // Back-to-back reads on port 0
        nren = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, AW'(4 * i), 1'b1, 1'b0, 32'h0, 1'b1, g0, g1);
            if (bus.im_ren) nren++;
        end
        check("b2b_ren_count", 64'(nren), 64'(3));
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, g0, g1);

        // Reset while a response is pending
        cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, g0, g1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, g0, g1);
        check("reset_drops_rvalid0", 64'(bus.rvalid0), 64'(0));
        for (int i = 0; i < INIT_WAIT + 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, g0, g1);

        // Randomized traffic; requests hold until granted
        h0 = 1'b0; h1 = 1'b0; a0 = '0; a1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!h0 && ($urandom_range(0, 2) != 0)) begin h0 = 1'b1; a0 = $urandom; end
            if (!h1 && ($urandom_range(0, 2) != 0)) begin h1 = 1'b1; a1 = $urandom; end
            cycle(($urandom_range(0, 399) == 0), h0, a0, ($urandom_range(0, 3) != 0),
                  h1, a1, ($urandom_range(0, 3) != 0), g0, g1);
            if (g0) h0 = 1'b0;
            if (g1) h1 = 1'b0;
        end

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, g0, g1);
        check("q0_drained", 64'(q0.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
